// File: rtl/miner_pkg.sv
// miner_pkg: shared types for the multi-core job dispatch path.
//   NONCE_W     - nonce width in bits
//   nonce_t     - one nonce
//   nonce_ext_t - nonce plus a carry bit, so window sizes up to 2^32 fit
//   state_e     - dispatch FSM states
package miner_pkg;

    localparam int unsigned NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [NONCE_W:0]   nonce_ext_t;

    typedef enum logic [1:0] {
        StIdle,
        StSplit,
        StStart,
        StRun
    } state_e;

endpackage

// File: rtl/gn_fifo.sv
// gn_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset    - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and data; accepted when not full, or when full with a pop
//   pop           - remove the head; ignored when empty
//   rdata         - head entry, valid whenever empty is low
//   full, empty   - occupancy flags
module gn_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/miner_job_dispatch.sv
// miner_job_dispatch: splits one job's nonce window across NUM_CORES hash cores and
// funnels their golden nonces back through a round-robin arbiter and a FWFT FIFO.
//   hash_clk, reset            - clock, synchronous active-high reset
//   new_work, nonce_min/max    - job start pulse and inclusive nonce window
//   core_reset/enable          - per-core start pulse and sub-range-valid mask
//   core_nonce_min/max         - packed per-core sub-ranges (core i at [32i+31:32i])
//   core_golden_nonce/new_...  - packed per-core results and found pulses
//   gn_data/valid/ready        - result stream towards the comm block
//   gn_core                    - head result's core index (only with GN_CORE_TAG_EN)
//   busy, job_error, overflow  - status
// Optional feature macro: GN_CORE_TAG_EN.
module miner_job_dispatch
    import miner_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                           hash_clk,
    input  logic                           reset,
    input  logic                           new_work,
    input  logic [NONCE_W-1:0]             nonce_min,
    input  logic [NONCE_W-1:0]             nonce_max,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES-1:0]           core_enable,
    output logic [NONCE_W*NUM_CORES-1:0]   core_nonce_min,
    output logic [NONCE_W*NUM_CORES-1:0]   core_nonce_max,
    input  logic [NONCE_W*NUM_CORES-1:0]   core_golden_nonce,
    input  logic [NUM_CORES-1:0]           core_new_golden_nonce,
    output logic [NONCE_W-1:0]             gn_data,
    output logic                           gn_valid,
`ifdef GN_CORE_TAG_EN
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] gn_core,
`endif
    input  logic                           gn_ready,
    output logic                           busy,
    output logic                           job_error,
    output logic                           overflow
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned LOG_N = $clog2(NUM_CORES);

    // ---------------- split FSM ----------------
    state_e               state;
    logic [IDX_W-1:0]     k;
    nonce_t               job_min, job_max;
    nonce_ext_t           next_min;
    nonce_ext_t           total, chunk;
    nonce_t               seg_max, k_max;
    logic                 k_en, last_core;
    logic [NUM_CORES-1:0] mask_next;

    always_comb begin
        total     = {1'b0, job_max} - {1'b0, job_min} + nonce_ext_t'(1);
        chunk     = total >> LOG_N;
        seg_max   = nonce_t'(next_min + chunk - nonce_ext_t'(1));
        last_core = (k == IDX_W'(NUM_CORES - 1));
        // A window smaller than NUM_CORES goes entirely to core 0.
        k_en      = (chunk != '0) || (k == '0);
        k_max     = (last_core || chunk == '0) ? job_max : seg_max;
        mask_next = core_enable;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (k == IDX_W'(i)) mask_next[i] = k_en;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state          <= StIdle;
            k              <= '0;
            job_min        <= '0;
            job_max        <= '0;
            next_min       <= '0;
            core_enable    <= '0;
            core_reset     <= '0;
            core_nonce_min <= '0;
            core_nonce_max <= '0;
            job_error      <= 1'b0;
        end else begin
            core_reset <= '0;
            if (new_work) begin
                job_min     <= nonce_min;
                job_max     <= nonce_max;
                next_min    <= {1'b0, nonce_min};
                k           <= '0;
                core_enable <= '0;
                job_error   <= 1'b0;
                state       <= StSplit;
            end else begin
                unique case (state)
                    StSplit: begin
                        if (job_max < job_min) begin
                            job_error <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            core_enable <= mask_next;
                            for (int i = 0; i < NUM_CORES; i++) begin
                                if (k == IDX_W'(i)) begin
                                    core_nonce_min[i*NONCE_W +: NONCE_W] <=
                                        k_en ? nonce_t'(next_min) : '0;
                                    core_nonce_max[i*NONCE_W +: NONCE_W] <=
                                        k_en ? k_max : '0;
                                end
                            end
                            next_min <= next_min + chunk;
                            if (last_core) begin
                                core_reset <= mask_next;
                                state      <= StStart;
                            end else begin
                                k <= k + IDX_W'(1);
                            end
                        end
                    end
                    StStart: state <= StRun;
                    default: state <= state;
                endcase
            end
        end
    end

    assign busy = (state == StSplit) || (state == StStart);

    // ---------------- capture and arbitration ----------------
    logic [NUM_CORES-1:0] pending, capture;
    nonce_t               held [NUM_CORES];
    logic [IDX_W-1:0]     rr, grant_idx;
    logic                 granted;
    logic [NUM_CORES-1:0] grant;
    logic                 fifo_full, fifo_empty;

    assign capture = (state == StRun) ? (core_new_golden_nonce & core_enable) : '0;

    always_comb begin
        granted   = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            int unsigned idx;
            idx = (int'(rr) + j) % NUM_CORES;
            if (!granted && pending[idx] && !fifo_full) begin
                granted   = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        grant = granted ? (NUM_CORES'(1) << grant_idx) : '0;
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pending  <= '0;
            rr       <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) held[i] <= '0;
        end else begin
            if (granted) begin
                rr <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (new_work) begin
                    pending[i] <= 1'b0;
                end else if (capture[i] && (!pending[i] || grant[i])) begin
                    // Slot is free or being drained this cycle: take the new value.
                    held[i]    <= core_golden_nonce[i*NONCE_W +: NONCE_W];
                    pending[i] <= 1'b1;
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end else if (capture[i]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // ---------------- result FIFO ----------------
`ifdef GN_CORE_TAG_EN
    localparam int unsigned FIFO_W = NONCE_W + IDX_W;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    assign fifo_wdata         = {grant_idx, held[grant_idx]};
    assign {gn_core, gn_data} = fifo_rdata;
`else
    localparam int unsigned FIFO_W = NONCE_W;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    assign fifo_wdata = held[grant_idx];
    assign gn_data    = fifo_rdata;
`endif

    assign gn_valid = !fifo_empty;

    gn_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_gn_fifo (
        .clk   (hash_clk),
        .reset (reset),
        .push  (granted),
        .wdata (fifo_wdata),
        .pop   (gn_valid && gn_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_miner_job_dispatch.sv
// tb_miner_job_dispatch: directed bench for miner_job_dispatch with NUM_CORES=4, FIFO_DEPTH=8.
module tb_miner_job_dispatch;

    localparam int unsigned N = 4;

    logic             hash_clk = 1'b0;
    logic             reset;
    logic             new_work;
    logic [31:0]      nonce_min, nonce_max;
    logic [N-1:0]     core_reset, core_enable;
    logic [32*N-1:0]  core_nonce_min, core_nonce_max;
    logic [32*N-1:0]  core_golden_nonce;
    logic [N-1:0]     core_new_golden_nonce;
    logic [31:0]      gn_data;
    logic             gn_valid, gn_ready;
    logic             busy, job_error, overflow;
`ifdef GN_CORE_TAG_EN
    logic [1:0]       gn_core;
`endif

    int n_vec = 0;
    int n_err = 0;

    miner_job_dispatch #(
        .NUM_CORES  (N),
        .FIFO_DEPTH (8)
    ) dut (
        .hash_clk              (hash_clk),
        .reset                 (reset),
        .new_work              (new_work),
        .nonce_min             (nonce_min),
        .nonce_max             (nonce_max),
        .core_reset            (core_reset),
        .core_enable           (core_enable),
        .core_nonce_min        (core_nonce_min),
        .core_nonce_max        (core_nonce_max),
        .core_golden_nonce     (core_golden_nonce),
        .core_new_golden_nonce (core_new_golden_nonce),
        .gn_data               (gn_data),
        .gn_valid              (gn_valid),
`ifdef GN_CORE_TAG_EN
        .gn_core               (gn_core),
`endif
        .gn_ready              (gn_ready),
        .busy                  (busy),
        .job_error             (job_error),
        .overflow              (overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    // Leaves the bench just after the edge that samples new_work (cycle 1).
    task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
        new_work  = 1'b1;
        nonce_min = lo;
        nonce_max = hi;
        step();
        new_work  = 1'b0;
    endtask

    task automatic check_range(input int i, input logic [31:0] lo, input logic [31:0] hi);
        check($sformatf("core%0d_min", i), core_nonce_min[32*i +: 32], lo);
        check($sformatf("core%0d_max", i), core_nonce_max[32*i +: 32], hi);
    endtask

    initial begin
        reset                 = 1'b1;
        new_work              = 1'b0;
        nonce_min             = '0;
        nonce_max             = '0;
        core_golden_nonce     = '0;
        core_new_golden_nonce = '0;
        gn_ready              = 1'b0;
        step();
        step();
        check("rst_core_reset", 32'(core_reset), 32'h0);
        check("rst_core_enable", 32'(core_enable), 32'h0);
        check("rst_gn_valid", 32'(gn_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_job_error", 32'(job_error), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        step();

        // Full 32-bit window: four equal quarters, start pulse in cycle 5.
        start_job(32'h0000_0000, 32'hFFFF_FFFF);
        check("full_busy_split", 32'(busy), 32'h1);
        step(); step(); step();
        check("full_core_reset_c4", 32'(core_reset), 32'h0);
        step();
        check("full_core_reset_c5", 32'(core_reset), 32'hF);
        check("full_core_enable", 32'(core_enable), 32'hF);
        check("full_busy_start", 32'(busy), 32'h1);
        check_range(0, 32'h0000_0000, 32'h3FFF_FFFF);
        check_range(1, 32'h4000_0000, 32'h7FFF_FFFF);
        check_range(2, 32'h8000_0000, 32'hBFFF_FFFF);
        check_range(3, 32'hC000_0000, 32'hFFFF_FFFF);
        step();
        check("full_core_reset_c6", 32'(core_reset), 32'h0);
        check("full_busy_run", 32'(busy), 32'h0);

        // 11 nonces: chunk 2, last core absorbs the remainder.
        start_job(32'h100, 32'h10A);
        step(); step(); step(); step();
        check("rem_core_reset", 32'(core_reset), 32'hF);
        check_range(0, 32'h100, 32'h101);
        check_range(1, 32'h102, 32'h103);
        check_range(2, 32'h104, 32'h105);
        check_range(3, 32'h106, 32'h10A);

        // 3 nonces: chunk 0, core 0 only.
        start_job(32'h100, 32'h102);
        step(); step(); step(); step();
        check("small_core_reset", 32'(core_reset), 32'h1);
        check("small_core_enable", 32'(core_enable), 32'h1);
        check_range(0, 32'h100, 32'h102);

        // Inverted window: error, nothing enabled or started.
        start_job(32'h5, 32'h4);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("err_core_reset_%0d", i), 32'(core_reset), 32'h0);
        end
        check("err_job_error", 32'(job_error), 32'h1);
        check("err_core_enable", 32'(core_enable), 32'h0);
        check("err_busy", 32'(busy), 32'h0);

        // Back to a good job and into RUN.
        start_job(32'h0000_0000, 32'hFFFF_FFFF);
        check("job_error_cleared", 32'(job_error), 32'h0);
        step(); step(); step(); step(); step();

        // Cores 1 and 3 fire together; round robin from 0 serves core 1 first.
        gn_ready                       = 1'b1;
        core_golden_nonce[32*1 +: 32]  = 32'hAAAA_0001;
        core_golden_nonce[32*3 +: 32]  = 32'hBBBB_0003;
        core_new_golden_nonce          = 4'b1010;
        step();
        core_new_golden_nonce          = '0;
        check("rr_valid_c0", 32'(gn_valid), 32'h0);
        step();
        check("rr_valid_c1", 32'(gn_valid), 32'h1);
        check("rr_data_first", gn_data, 32'hAAAA_0001);
`ifdef GN_CORE_TAG_EN
        check("rr_tag_first", 32'(gn_core), 32'h1);
`endif
        step();
        check("rr_valid_c2", 32'(gn_valid), 32'h1);
        check("rr_data_second", gn_data, 32'hBBBB_0003);
`ifdef GN_CORE_TAG_EN
        check("rr_tag_second", 32'(gn_core), 32'h3);
`endif
        step();
        check("rr_valid_c3", 32'(gn_valid), 32'h0);

        // Back-pressure: 8 results fill the FIFO, the 9th waits in pending.
        gn_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            core_golden_nonce[31:0] = 32'h1000_0000 + 32'(i);
            core_new_golden_nonce   = 4'b0001;
            step();
            core_new_golden_nonce   = '0;
            step();
        end
        check("bp_overflow_before", 32'(overflow), 32'h0);
        check("bp_head", gn_data, 32'h1000_0000);
        // A 10th while the 9th is still pending is dropped.
        core_golden_nonce[31:0] = 32'hDEAD_0010;
        core_new_golden_nonce   = 4'b0001;
        step();
        core_new_golden_nonce   = '0;
        step();
        check("bp_overflow_after", 32'(overflow), 32'h1);
        gn_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("bp_valid_%0d", i), 32'(gn_valid), 32'h1);
            check($sformatf("bp_data_%0d", i), gn_data, 32'h1000_0000 + 32'(i));
            step();
        end
        check("bp_drained", 32'(gn_valid), 32'h0);

        // Stale pulse during SPLIT, then a restart mid-SPLIT.
        start_job(32'h0000_0000, 32'h0000_03FF);
        core_golden_nonce[32*2 +: 32] = 32'h2222_2222;
        core_new_golden_nonce         = 4'b0100;
        step();
        core_new_golden_nonce         = '0;
        start_job(32'h0000_2000, 32'h0000_2FFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("restart_core_reset_%0d", i), 32'(core_reset), 32'h0);
        end
        step();
        check("restart_core_reset", 32'(core_reset), 32'hF);
        check_range(0, 32'h2000, 32'h23FF);
        check_range(3, 32'h2C00, 32'h2FFF);
        step(); step(); step();
        check("stale_discarded", 32'(gn_valid), 32'h0);
        check("overflow_sticky", 32'(overflow), 32'h1);

        // Only reset clears overflow.
        reset = 1'b1;
        step();
        check("rst2_overflow", 32'(overflow), 32'h0);
        check("rst2_core_enable", 32'(core_enable), 32'h0);
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
